// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encodings and FSM states.
package logic_unit_arbiter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND  = 2'b00;
    localparam op_t OP_OR   = 2'b01;
    localparam op_t OP_XOR  = 2'b10;
    localparam op_t OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_shared_logic_unit.sv
// Shared WIDTH-bit two-input logic unit: per-bit primitive gates feeding an
// opcode-selected output. Purely combinational; the caller registers the result.
module shared_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] and_w;
    logic [WIDTH-1:0] or_w;
    logic [WIDTH-1:0] xor_w;
    logic [WIDTH-1:0] nand_w;

    // One gate of each kind per bit; no carries between bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        and  u_and  (and_w[gi],  a_i[gi], b_i[gi]);
        or   u_or   (or_w[gi],   a_i[gi], b_i[gi]);
        xor  u_xor  (xor_w[gi],  a_i[gi], b_i[gi]);
        nand u_nand (nand_w[gi], a_i[gi], b_i[gi]);
    end

    // Select the gate array output matching the opcode.
    always_comb begin
        y_o = and_w;
        case (op_i)
            OP_AND:  y_o = and_w;
            OP_OR:   y_o = or_w;
            OP_XOR:  y_o = xor_w;
            OP_NAND: y_o = nand_w;
            default: y_o = and_w;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one registered logic unit among N
// requesters: grant, hold operands for LATENCY cycles, then pulse done with y.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [2*N-1:0]     op,
    input  logic [WIDTH*N-1:0] a,
    input  logic [WIDTH*N-1:0] b,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic [WIDTH-1:0]   y,
    output logic               busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Unpacked views of the per-requester operand buses.
    op_t              op_arr [N];
    logic [WIDTH-1:0] a_arr  [N];
    logic [WIDTH-1:0] b_arr  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign op_arr[gi] = op_t'(op[2*gi +: 2]);
        assign a_arr[gi]  = a[WIDTH*gi +: WIDTH];
        assign b_arr[gi]  = b[WIDTH*gi +: WIDTH];
    end

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   w_q;
    logic [CNT_W-1:0]   cnt_q;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [N-1:0]       gnt_q;
    logic [N-1:0]       done_q;
    logic [WIDTH-1:0]   y_q;
    logic               busy_q;

    // Requests at or above the pointer get first pick; otherwise wrap to the
    // lowest index. This yields the ptr, ptr+1, ... mod N search for any N.
    logic [N-1:0]       hi_mask;
    logic [N-1:0]       req_hi;
    logic [PTR_W-1:0]   win_d;
    logic [PTR_W-1:0]   ptr_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign hi_mask[gi] = (PTR_W'(gi) >= ptr_q);
    end

    assign req_hi = req & hi_mask;

    // Priority-encode the lowest set bit of the wrapped request window.
    always_comb begin
        win_d = '0;
        if (|req_hi) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_hi[i]) win_d = PTR_W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) win_d = PTR_W'(i);
            end
        end
    end

    assign ptr_d = (win_d == PTR_W'(N - 1)) ? '0 : win_d + 1'b1;

    // The shared unit only ever sees the operands captured at grant time.
    logic [WIDTH-1:0] y_d;

    shared_logic_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (y_d)
    );

    // FSM with all outputs registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= '0;
                    gnt_q  <= '0;
                    if (|req) begin
                        w_q     <= win_d;
                        op_q    <= op_arr[win_d];
                        a_q     <= a_arr[win_d];
                        b_q     <= b_arr[win_d];
                        gnt_q   <= N'(1) << win_d;
                        ptr_q   <= ptr_d;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    gnt_q <= '0;
                    if (cnt_q == '0) begin
                        done_q  <= N'(1) << w_q;
                        y_q     <= y_d;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign y    = y_q;
    assign busy = busy_q;

endmodule
